// File: rtl/flipflop_pkg.sv
// Shared constants and helpers for the flipflop storage primitive.
// Holds the preset/clear priority policy, the default width, and the
// test-vector field widths that benches reuse.
package flipflop_pkg;

  // Number of stored bits when the instantiating module does not override WIDTH.
  localparam int FF_DEFAULT_WIDTH = 1;

  // Priority policy when preset and clear are asserted together.
  // The value is fixed at 1, so clear wins and the register goes to all-zeros.
  // Either policy keeps qbar the complement of q, because qbar is always
  // derived from the single stored value. Fixing the policy here gives every
  // user of the primitive the same answer.
  localparam bit FF_CLEAR_WINS = 1'b1;

  // Test-vector field widths: one multi-bit data lane plus three control bits
  // (data-lane MSB, preset, clear) walked by the benches.
  localparam int TV_DATA_W = 4;
  localparam int TV_CTRL_W = 3;
  localparam int TV_W      = TV_DATA_W + TV_CTRL_W;

  // Which source feeds the next state of a bit at a clock edge.
  // The asynchronous reset is listed for completeness. It never comes from
  // the synchronous selector below.
  typedef enum logic [1:0] {
    FF_SEL_DATA   = 2'd0,
    FF_SEL_PRESET = 2'd1,
    FF_SEL_CLEAR  = 2'd2,
    FF_SEL_RESET  = 2'd3
  } ff_sel_e;

  // Resolve the synchronous controls into one source selection,
  // applying the clear/preset priority policy.
  function automatic ff_sel_e ff_select(input logic clear, input logic preset);
    ff_sel_e sel;
    sel = FF_SEL_DATA;
    if (clear && (FF_CLEAR_WINS || !preset)) begin
      sel = FF_SEL_CLEAR;
    end else if (preset) begin
      sel = FF_SEL_PRESET;
    end
    return sel;
  endfunction

endpackage

// File: rtl/flipflop_cell.sv
// One bit of storage for the flipflop primitive.
// An asynchronous reset loads rst_val. At each rising clock edge the cell
// then applies clear, then preset, then the d input, highest priority first.
// There is no combinational path from d, preset or clear to q or qbar.
module flipflop_cell
  import flipflop_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  input  logic preset,
  input  logic clear,
  input  logic rst_val,
  output logic q,
  output logic qbar
);

  logic    state_q;
  logic    state_d;
  ff_sel_e sel;

  // Next-state selection for the synchronous controls.
  // X on d passes straight through to the register.
  always_comb begin
    sel     = ff_select(clear, preset);
    state_d = d;
    case (sel)
      FF_SEL_CLEAR:  state_d = 1'b0;
      FF_SEL_PRESET: state_d = 1'b1;
      default:       state_d = d;
    endcase
  end

  // The storage bit. Reset takes effect immediately and holds while it is
  // asserted. The load is discarded whenever reset is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= rst_val;
    end else begin
      state_q <= state_d;
    end
  end

  assign q    = state_q;
  assign qbar = ~state_q;

endmodule

// File: rtl/flipflop.sv
// Parameterised D-type storage register with synchronous preset and clear,
// an asynchronous master reset, and complementary outputs.
// Each bit is an independent flipflop_cell. Bit i resets to RESET_VALUE[i].
// The top drives qbar directly from q, so the two outputs cannot disagree.
module flipflop
  import flipflop_pkg::*;
#(
  parameter int               WIDTH       = FF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             preset,
  input  logic             clear,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  // The per-cell complement outputs are not used here, because qbar is
  // formed from the assembled q vector below.
  logic [WIDTH-1:0] qbar_unused;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    flipflop_cell u_cell (
      .clk     (clk),
      .reset   (reset),
      .d       (data[i]),
      .preset  (preset),
      .clear   (clear),
      .rst_val (RESET_VALUE[i]),
      .q       (q[i]),
      .qbar    (qbar_unused[i])
    );
  end

  assign qbar = ~q;

endmodule

// File: tb/tb_flipflop.sv
// Bench for flipflop. It drives two instances from shared controls:
// a 1-bit instance that resets to 0, and a 4-bit instance that resets to 4'b1010.
// Expected values come from a priority model of reset, clear, preset and
// data, and are queued one edge ahead of the output samples.
module tb_flipflop;
  import flipflop_pkg::*;

  localparam int             WB   = TV_DATA_W;
  localparam logic [WB-1:0]  RV_B = 4'b1010;
  localparam logic [WB-1:0]  ONES = {WB{1'b1}};

  logic          clk = 1'b0;
  logic          reset;
  logic          preset;
  logic          clear;
  logic          data_a;
  logic [WB-1:0] data_b;
  logic          q_a;
  logic          qbar_a;
  logic [WB-1:0] q_b;
  logic [WB-1:0] qbar_b;

  // Scoreboard entry layout: bit WB is the expected q of instance a.
  // Bits WB-1:0 are the expected q of instance b.
  logic [WB:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Clock: period 10. Rising edges fall at 5, 15, 25, and so on.
  always #5 clk = ~clk;

  flipflop #(.WIDTH(1), .RESET_VALUE(1'b0)) dut_a (
    .clk    (clk),
    .reset  (reset),
    .data   (data_a),
    .preset (preset),
    .clear  (clear),
    .q      (q_a),
    .qbar   (qbar_a)
  );

  flipflop #(.WIDTH(WB), .RESET_VALUE(RV_B)) dut_b (
    .clk    (clk),
    .reset  (reset),
    .data   (data_b),
    .preset (preset),
    .clear  (clear),
    .q      (q_b),
    .qbar   (qbar_b)
  );

  // Reference: the value each register holds after an edge with these inputs.
  function automatic logic [WB:0] model(input logic da, input logic [WB-1:0] db,
                                        input logic p, input logic c, input logic r);
    if (r) return {1'b0, RV_B};
    if (c) return {1'b0, {WB{1'b0}}};
    if (p) return {1'b1, ONES};
    return {da, db};
  endfunction

  task automatic check(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [WB:0] e);
    check({tag, ".q_a"},    {{(WB-1){1'b0}}, q_a},    {{(WB-1){1'b0}}, e[WB]});
    check({tag, ".qbar_a"}, {{(WB-1){1'b0}}, qbar_a}, {{(WB-1){1'b0}}, ~e[WB]});
    check({tag, ".q_b"},    q_b,    e[WB-1:0]);
    check({tag, ".qbar_b"}, qbar_b, ~e[WB-1:0]);
  endtask

  // Driver. Inputs change 1 unit after a rising edge.
  // At the following falling edge, the outputs show the capture of the
  // previous step's inputs, which is the entry at the front of the queue.
  task automatic step(input logic da, input logic [WB-1:0] db,
                      input logic p, input logic c, input string tag);
    @(posedge clk);
    #1;
    data_a = da;
    data_b = db;
    preset = p;
    clear  = c;
    @(negedge clk);
    if (exp_q.size() > 0) check_all(tag, exp_q.pop_front());
    exp_q.push_back(model(da, db, p, c, 1'b0));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held for 27 units while data and preset are high.
    reset  = 1'b1;
    data_a = 1'b1;
    data_b = ONES;
    preset = 1'b1;
    clear  = 1'b0;
    #1;
    check_all("reset_t1", model(1'b1, ONES, 1'b1, 1'b0, 1'b1));
    @(negedge clk);
    check_all("reset_t10", model(1'b1, ONES, 1'b1, 1'b0, 1'b1));
    @(negedge clk);
    check_all("reset_t20", model(1'b1, ONES, 1'b1, 1'b0, 1'b1));
    #7;
    reset = 1'b0;
    // Release at 27. q keeps the reset value until the edge at 35.
    @(negedge clk);
    check_all("release_hold", model(1'b1, ONES, 1'b1, 1'b0, 1'b1));
    exp_q.push_back(model(data_a, data_b, preset, clear, 1'b0));

    // Load path.
    step(1'b1, 4'h5, 1'b0, 1'b0, "first_edge");
    step(1'b0, 4'hA, 1'b0, 1'b0, "load1");
    step(1'b1, 4'h3, 1'b0, 1'b0, "load0");
    step(1'b1, 4'hC, 1'b0, 1'b0, "load1b");
    // Preset, then clear and preset together.
    step(1'b0, 4'h0, 1'b1, 1'b0, "load1c");
    step(1'b1, 4'hF, 1'b1, 1'b1, "preset");
    step(1'b1, 4'hF, 1'b0, 1'b0, "clear_wins");
    step(1'b1, 4'hF, 1'b0, 1'b0, "load_f");

    // Asynchronous reset between edges, with q = 1 and no clock edge needed.
    #2;
    reset = 1'b1;
    #1;
    check_all("async_rst", model(1'b1, ONES, 1'b0, 1'b0, 1'b1));
    exp_q.delete();
    @(posedge clk);
    #1;
    check_all("rst_held", model(1'b1, ONES, 1'b0, 1'b0, 1'b1));
    reset = 1'b0;
    @(negedge clk);
    check_all("rst_release", model(1'b1, ONES, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(model(data_a, data_b, preset, clear, 1'b0));

    // Vector run. All {data, preset, clear} combinations are walked first,
    // then fully random vectors follow.
    for (int i = 0; i < 128; i++) begin
      logic          da;
      logic          p;
      logic          c;
      logic [WB-1:0] db;
      logic [2:0]    combo;
      db = WB'($urandom_range(0, (1 << WB) - 1));
      if (i < 64) begin
        combo = 3'(i);
        da = combo[2];
        p  = combo[1];
        c  = combo[0];
      end else begin
        da = 1'($urandom_range(0, 1));
        p  = 1'($urandom_range(0, 1));
        c  = 1'($urandom_range(0, 1));
      end
      step(da, db, p, c, "vector");
    end
    step(1'b0, 4'h0, 1'b0, 1'b0, "drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/flipflop.md
# flipflop

Parameterised D-type storage register with synchronous preset and clear, an asynchronous master reset, and complementary outputs. It is the basic state-holding primitive used by the other modules in the codebase for single-bit flags and narrow registers. Per bit, it captures `data` on the rising edge of `clk`, with preset and clear overriding the data path. `qbar` is always the bitwise complement of `q`.

## Interface
Parameters:
- `WIDTH`, default 1: number of stored bits.
- `RESET_VALUE`, default all-zeros (`WIDTH` bits): value loaded by `reset`.

Ports:
- `clk`  input  1  sole clock; all synchronous behaviour on rising edge.
- `reset`  input  1  asynchronous, active-high master reset.
- `data`  input  WIDTH  next-state value for the normal load path.
- `preset`  input  1  synchronous, active-high; sets every bit of `q` to 1.
- `clear`  input  1  synchronous, active-high; sets every bit of `q` to 0.
- `q`  output  WIDTH  registered state.
- `qbar`  output  WIDTH  always equals `~q`.

## Operation
- Priority at each rising edge of `clk`, highest first:
  1. `reset`
  2. `clear`
  3. `preset`
  4. `data` load
- Reset:
  - `reset` high forces `q = RESET_VALUE` and `qbar = ~RESET_VALUE` immediately, independent of `clk`.
  - `q` holds that value while `reset` stays high.
- `clear` high with `reset` low: `q <= 0` at the edge.
- `preset` high with `clear` and `reset` low: `q <= {WIDTH{1'b1}}`.
- Otherwise: `q <= data`.
- `preset` and `clear` both high: `clear` wins, so `q <= 0`. `q` and `qbar` are never driven to the same value.
- `qbar` is derived combinationally from `q`. There is no separate `qbar` register, so the two cannot diverge.
- Unknown (X) on `data` propagates to `q`. X on `preset` or `clear` has no defined behaviour; the bench must not drive it.

## Timing
- Latency: one rising edge from input to `q`.
- Inputs must be stable in the setup and hold window around the rising edge. The bench changes inputs 1 time unit after the rising edge and samples outputs on the falling edge.
- Reset assertion: asynchronous, takes effect within the same delta.
- Reset deassertion:
  - `q` keeps `RESET_VALUE` until the first rising edge with `reset` low.
  - That edge applies the normal priority rules.
  - Deassertion must be synchronised upstream. This block does no reset synchronisation.
- Reset asserted mid-operation: any pending load is discarded and `q` goes to `RESET_VALUE` immediately.
- No combinational path from `data`, `preset` or `clear` to `q` or `qbar`.

## Structure
- Sub-module `flipflop_cell`:
  - One bit with ports `clk`, `reset`, `d`, `preset`, `clear`, `rst_val`, `q`, `qbar`.
  - The top level instantiates it `WIDTH` times in a generate loop.
  - Bit `i` receives `RESET_VALUE[i]`.
- The top level contains only the generate loop and the `qbar = ~q` assignment.
- Shared package `flipflop_pkg`:
  - `FF_CLEAR_WINS`, a priority constant fixed to 1 and documented.
  - A default-width constant.
  - Any test-vector field-width constants used by benches.

## Test plan
- Reset: `reset` = 1 for 27 time units with `data` = 1 and `preset` = 1 → `q` = `RESET_VALUE` (0) and `qbar` = 1 throughout. First edge after release with `data` = 1 → `q` = 1.
- Load: `reset` = 0, `preset` = 0, `clear` = 0, `data` sequence 1, 0, 1, 1 → `q` follows one edge later, `qbar` is its complement every cycle.
- Preset: `data` = 0, `preset` = 1 → `q` = 1 at the next edge. With `WIDTH` = 4 → `q` = 4'b1111.
- Clear priority: `preset` = 1, `clear` = 1, `data` = 1 → `q` = 0, `qbar` = 1.
- Async reset mid-cycle: `q` = 1, assert `reset` between edges → `q` = 0 before the next edge, with no `clk` edge required.
- Vector run: walk every combination of {`data`, `preset`, `clear`} for ≥100 cycles against a reference model → zero mismatches. Report the count of tests and errors when the vector file is exhausted (next entry all-X).
